// File: rtl/ode_step_sequencer.sv
// rtl/ode_step_sequencer.sv - step sequencer for an ODE solver datapath with watchdog
module ode_step_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 1024,
    parameter int TO_WIDTH  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [WORD_SIZE-1:0] cfg_steps,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 step_done,
    output logic                 step_start,
    output logic [WORD_SIZE-1:0] step_index,
    output logic [WORD_SIZE-1:0] steps_left,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Watchdog terminal count; zero TIMEOUT disables the check entirely.
    localparam logic [TO_WIDTH-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

    state_t                state, state_n;
    logic [WORD_SIZE-1:0]  limit, limit_n;
    logic [WORD_SIZE-1:0]  index_n;
    logic [WORD_SIZE-1:0]  index_inc;
    logic [TO_WIDTH-1:0]   watchdog, watchdog_n;
    logic                  idle_like;

    assign index_inc = step_index + WORD_SIZE'(1);
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);

    // Outputs are decoded from state and registers only, never from inputs.
    assign step_start  = (state == ISSUE);
    assign busy        = (state == ISSUE) || (state == WAIT);
    assign done        = (state == DONE);
    assign timeout_err = (state == ERROR);
    assign steps_left  = limit - step_index;

    // State and datapath registers; reset clears everything including a pending start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            limit      <= '0;
            step_index <= '0;
            watchdog   <= '0;
        end else begin
            state      <= state_n;
            limit      <= limit_n;
            step_index <= index_n;
            watchdog   <= watchdog_n;
        end
    end

    // Next-state logic with priority abort > step_done > timeout > go.
    always_comb begin
        state_n    = state;
        limit_n    = limit;
        index_n    = step_index;
        watchdog_n = watchdog;

        // A new limit is only accepted while not running; a same-cycle go still sees the old one.
        if (idle_like && cfg_valid) begin
            limit_n = cfg_steps;
        end

        if (abort && (state != IDLE)) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (go) begin
                        index_n = '0;
                        state_n = (limit != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    watchdog_n = '0;
                    state_n    = WAIT;
                end
                WAIT: begin
                    watchdog_n = watchdog + TO_WIDTH'(1);
                    if (step_done) begin
                        index_n = index_inc;
                        state_n = (index_inc == limit) ? DONE : ISSUE;
                    end else if ((TIMEOUT != 0) && (watchdog == TO_LAST)) begin
                        state_n = ERROR;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ode_step_sequencer.sv
// tb/tb_ode_step_sequencer.sv - directed self-checking bench for ode_step_sequencer
module tb_ode_step_sequencer;

    localparam int WS = 32;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic [WS-1:0] cfg_steps;
    logic          go;
    logic          abort;
    logic          step_done;
    logic          step_start;
    logic [WS-1:0] step_index;
    logic [WS-1:0] steps_left;
    logic          busy;
    logic          done;
    logic          timeout_err;

    int checks = 0;
    int passes = 0;

    ode_step_sequencer #(
        .WORD_SIZE (WS),
        .TIMEOUT   (8),
        .TO_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_steps   (cfg_steps),
        .go          (go),
        .abort       (abort),
        .step_done   (step_done),
        .step_start  (step_start),
        .step_index  (step_index),
        .steps_left  (steps_left),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [WS-1:0] n);
        cfg_valid = 1'b1;
        cfg_steps = n;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic start_run;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] outs;
        outs = {step_start, busy, done, timeout_err, |step_index, |steps_left};
        checks++;
        if (outs !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", outs);
        else passes++;
    endtask

    task automatic test_normal_run;
        int starts;
        starts = 0;
        configure(3);
        start_run();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (step_start !== 1'b1 || step_index !== WS'(k) || steps_left !== WS'(3 - k))
                $display("FAIL run_issue_%0d: start=%b idx=%0d left=%0d want 1 %0d %0d",
                         k, step_start, step_index, steps_left, k, 3 - k);
            else passes++;
            starts++;
            repeat (4) begin
                tick();
                if (step_start) starts++;
            end
            step_done = 1'b1;
            tick();
            step_done = 1'b0;
        end
        checks++;
        if (starts !== 3) $display("FAIL run_start_count: got %0d want 3", starts);
        else passes++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || step_index !== WS'(3) || steps_left !== '0)
            $display("FAIL run_done: done=%b busy=%b idx=%0d left=%0d want 1 0 3 0",
                     done, busy, step_index, steps_left);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b1) $display("FAIL run_done_hold: got %b want 1", done);
        else passes++;
    endtask

    task automatic test_zero_limit;
        configure(0);
        start_run();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || step_start !== 1'b0 || step_index !== '0)
            $display("FAIL zero_limit: done=%b busy=%b start=%b idx=%0d want 1 0 0 0",
                     done, busy, step_start, step_index);
        else passes++;
    endtask

    task automatic test_timeout;
        int bad;
        bad = 0;
        configure(5);
        start_run();
        checks++;
        if (step_start !== 1'b1) $display("FAIL timeout_issue: got %b want 1", step_start);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy !== 1'b1 || timeout_err !== 1'b0 || step_start !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL timeout_wait_cycles: got %0d bad cycles want 0", bad);
        else passes++;
        tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || step_index !== '0 || steps_left !== WS'(5))
            $display("FAIL timeout_err: err=%b busy=%b idx=%0d left=%0d want 1 0 0 5",
                     timeout_err, busy, step_index, steps_left);
        else passes++;
        start_run();
        checks++;
        if (step_start !== 1'b1 || step_index !== '0 || timeout_err !== 1'b0)
            $display("FAIL timeout_restart: start=%b idx=%0d err=%b want 1 0 0",
                     step_start, step_index, timeout_err);
        else passes++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort;
        int starts;
        starts = 0;
        configure(4);
        start_run();
        tick();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        tick();
        step_done = 1'b1;
        abort     = 1'b1;
        tick();
        step_done = 1'b0;
        abort     = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step_index !== WS'(1) || steps_left !== WS'(3))
            $display("FAIL abort_idle: busy=%b done=%b idx=%0d left=%0d want 0 0 1 3",
                     busy, done, step_index, steps_left);
        else passes++;
        repeat (3) begin
            if (step_start) starts++;
            tick();
        end
        checks++;
        if (starts !== 0) $display("FAIL abort_no_start: got %0d pulses want 0", starts);
        else passes++;
        start_run();
        checks++;
        if (step_start !== 1'b1 || step_index !== '0)
            $display("FAIL abort_restart: start=%b idx=%0d want 1 0", step_start, step_index);
        else passes++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_ignored_done;
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        checks++;
        if (step_index !== '0 || busy !== 1'b0)
            $display("FAIL done_in_idle: idx=%0d busy=%b want 0 0", step_index, busy);
        else passes++;
        configure(1);
        go = 1'b1;
        tick();
        go        = 1'b0;
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
        checks++;
        if (step_index !== '0 || busy !== 1'b1 || step_start !== 1'b0)
            $display("FAIL done_in_issue: idx=%0d busy=%b start=%b want 0 1 0",
                     step_index, busy, step_start);
        else passes++;
        step_done = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || step_index !== WS'(1))
            $display("FAIL single_step_done: done=%b idx=%0d want 1 1", done, step_index);
        else passes++;
        tick();
        step_done = 1'b0;
        checks++;
        if (done !== 1'b1 || step_index !== WS'(1) || steps_left !== '0)
            $display("FAIL done_in_done: done=%b idx=%0d left=%0d want 1 1 0",
                     done, step_index, steps_left);
        else passes++;
    endtask

    task automatic test_reset_mid_run;
        logic [5:0] outs;
        configure(10);
        start_run();
        repeat (6) begin
            tick();
            step_done = 1'b1;
            tick();
            step_done = 1'b0;
        end
        tick();
        checks++;
        if (step_index !== WS'(6) || busy !== 1'b1 || steps_left !== WS'(4))
            $display("FAIL mid_run_state: idx=%0d busy=%b left=%0d want 6 1 4",
                     step_index, busy, steps_left);
        else passes++;
        #2;
        rst = 1'b0;
        #1;
        outs = {step_start, busy, done, timeout_err, |step_index, |steps_left};
        checks++;
        if (outs !== 6'b0) $display("FAIL async_reset: got %b want 000000", outs);
        else passes++;
        tick();
        rst = 1'b1;
        tick();
        start_run();
        checks++;
        if (done !== 1'b1 || step_start !== 1'b0 || busy !== 1'b0)
            $display("FAIL limit_cleared: done=%b start=%b busy=%b want 1 0 0",
                     done, step_start, busy);
        else passes++;
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_steps = '0;
        go        = 1'b0;
        abort     = 1'b0;
        step_done = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        test_normal_run();
        test_zero_limit();
        test_timeout();
        test_abort();
        test_ignored_done();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
